point_fetch_arbiter: RTL and testbench

- Shares the single read port of the point data memory (2*Q points x D dimensions x N bits, combinational read) between R requesters, e.g. distance/centroid units.
- Round-robin arbitration; for each granted request, walks all D dimensions of one point and streams them back as tagged beats.
- Sits between the compute units and the memory; the top level zero-extends mem_addr to the memory's address port.

---
 rtl/point_fetch_arbiter_pkg.sv | 36 +++
 rtl/point_fetch_arbiter_if.sv | 47 ++++
 rtl/point_fetch_arbiter_rr_arbiter.sv | 39 +++
 rtl/point_fetch_arbiter.sv | 143 ++++++++++++++
 tb/tb_point_fetch_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/point_fetch_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | point_fetch_arbiter_pkg                                              |
// | Shared defaults, width helpers and FSM state type.                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package point_fetch_arbiter_pkg;

    localparam int c_DEF_Q = 100;
    localparam int c_DEF_D = 3;
    localparam int c_DEF_N = 16;
    localparam int c_DEF_R = 2;

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int addr_w(input int q);
        return clog2_min1(2 * q);
    endfunction

    function automatic int dim_w(input int d);
        return clog2_min1(d);
    endfunction

    function automatic int id_w(input int r);
        return clog2_min1(r);
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/point_fetch_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | point_fetch_arbiter_if                                               |
// | Requester handshake, memory read port and response beat bundle.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface point_fetch_arbiter_if
    import point_fetch_arbiter_pkg::*;
#(
    parameter int Q = c_DEF_Q,
    parameter int D = c_DEF_D,
    parameter int N = c_DEF_N,
    parameter int R = c_DEF_R
);
    localparam int ADDR_W = addr_w(Q);
    localparam int DIM_W  = dim_w(D);
    localparam int ID_W   = id_w(R);

    logic [R-1:0]        req;
    logic [R*ADDR_W-1:0] req_addr;
    logic [R-1:0]        gnt;
    logic                busy;
    logic                mem_read;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DIM_W-1:0]    mem_dim;
    logic [N-1:0]        mem_data;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [DIM_W-1:0]    rsp_dim;
    logic [N-1:0]        rsp_data;
    logic                rsp_err;
    logic                rsp_last;

    modport slave (
        input  req, req_addr, mem_data,
        output gnt, busy, mem_read, mem_addr, mem_dim,
        output rsp_valid, rsp_id, rsp_dim, rsp_data, rsp_err, rsp_last
    );

    modport master (
        output req, req_addr, mem_data,
        input  gnt, busy, mem_read, mem_addr, mem_dim,
        input  rsp_valid, rsp_id, rsp_dim, rsp_data, rsp_err, rsp_last
    );

endinterface
`default_nettype wire

// File: rtl/point_fetch_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick: first request above the pointer.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int R    = 2,
    parameter int ID_W = 1
) (
    input  wire logic [R-1:0]    i_req,
    input  wire logic [ID_W-1:0] i_ptr,
    output logic [R-1:0]         o_gnt_oh,
    output logic [ID_W-1:0]      o_gnt_idx,
    output logic                 o_any
);

    logic              w_found;
    logic [ID_W-1:0]   w_cand;

    // Offsets 1..R from the pointer; offset R revisits the last winner.
    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 1; k <= R; k++) begin
            w_cand = ID_W'((int'(i_ptr) + k) % R);
            if (!w_found && i_req[w_cand]) begin
                w_found           = 1'b1;
                o_gnt_oh[w_cand]  = 1'b1;
                o_gnt_idx         = w_cand;
            end
        end
        o_any = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/point_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | point_fetch_arbiter                                                  |
// | Shares the point memory read port among R requesters, one point/grant|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module point_fetch_arbiter
    import point_fetch_arbiter_pkg::*;
#(
    parameter int Q = c_DEF_Q,
    parameter int D = c_DEF_D,
    parameter int N = c_DEF_N,
    parameter int R = c_DEF_R
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    point_fetch_arbiter_if.slave bus
);

    localparam int ADDR_W   = addr_w(Q);
    localparam int DIM_W    = dim_w(D);
    localparam int ID_W     = id_w(R);
    localparam int c_NUM_PTS = 2 * Q;
    localparam logic [DIM_W-1:0] c_LAST_DIM = DIM_W'(D - 1);
    localparam logic [ID_W-1:0]  c_PTR_RST  = ID_W'(R - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_err;
    logic [DIM_W-1:0]   r_dim;

    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [DIM_W-1:0]   r_rsp_dim;
    logic [N-1:0]       r_rsp_data;
    logic               r_rsp_err;
    logic               r_rsp_last;

    logic [R-1:0]       w_win_oh;
    logic [ID_W-1:0]    w_win_idx;
    logic               w_any_req;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               w_sel_err;
    logic               w_accept;
    logic               w_last_rd;

    rr_arbiter #(
        .R    (R),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .i_req     (bus.req),
        .i_ptr     (r_ptr),
        .o_gnt_oh  (w_win_oh),
        .o_gnt_idx (w_win_idx),
        .o_any     (w_any_req)
    );

    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < R; i++) begin
            if (w_win_idx == ID_W'(i)) begin
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        w_sel_err = (int'(w_sel_addr) >= c_NUM_PTS);
    end

    // gnt/busy are combinational, so gate them with rst_n to keep every
    // output at its reset value while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last_rd   = (r_dim == c_LAST_DIM);
        case (r_state)
            IDLE: begin
                if (rst_n && w_any_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                if (w_last_rd) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= c_PTR_RST;
            r_id        <= '0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_dim       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_dim   <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_id   <= w_win_idx;
                r_ptr  <= w_win_idx;
                r_addr <= w_sel_addr;
                r_err  <= w_sel_err;
                r_dim  <= '0;
            end else if (r_state == READ && !w_last_rd) begin
                r_dim <= r_dim + 1'b1;
            end

            r_rsp_valid <= (r_state == READ);
            r_rsp_last  <= (r_state == READ) && w_last_rd;
            r_rsp_err   <= (r_state == READ) && r_err;
            if (r_state == READ) begin
                r_rsp_id   <= r_id;
                r_rsp_dim  <= r_dim;
                r_rsp_data <= r_err ? '0 : bus.mem_data;
            end
        end
    end

    assign bus.gnt       = w_accept ? w_win_oh : '0;
    assign bus.busy      = w_accept || (r_state == READ);
    assign bus.mem_read  = (r_state == READ) && !r_err;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_dim   = r_dim;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_dim   = r_rsp_dim;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_last  = r_rsp_last;

endmodule
`default_nettype wire

// File: tb/tb_point_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_point_fetch_arbiter                                               |
// | Directed table-driven bench with a addr*16+dim memory model.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_point_fetch_arbiter;
    import point_fetch_arbiter_pkg::*;

    localparam int Q = 100;
    localparam int D = 3;
    localparam int N = 16;
    localparam int R = 2;
    localparam int ADDR_W = addr_w(Q);

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    point_fetch_arbiter_if #(.Q(Q), .D(D), .N(N), .R(R)) bus ();

    point_fetch_arbiter #(.Q(Q), .D(D), .N(N), .R(R)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.mem_data = N'((int'(bus.mem_addr) << 4) + int'(bus.mem_dim));

    typedef struct {
        int r;
        int addr;
        int base;
        bit err;
    } txn_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_req(input int r, input bit v, input int addr);
        bus.req[r] = v;
        bus.req_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    task automatic run_txn(input int r, input int addr, input int base, input bit err);
        bit got = 1'b0;
        @(negedge clk);
        set_req(r, 1'b1, addr);
        #1;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bus.gnt != '0) got = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        chk("gnt_seen", 32'(got), 32'd1);
        if (!got) begin
            set_req(r, 1'b0, addr);
            return;
        end
        chk("gnt_onehot", 32'(bus.gnt), 32'(1 << r));
        chk("busy_at_gnt", 32'(bus.busy), 32'd1);
        @(negedge clk);
        set_req(r, 1'b0, addr);
        #1;
        for (int k = 0; k < D; k++) begin
            chk("mem_read", 32'(bus.mem_read), 32'(!err));
            chk("mem_addr", 32'(bus.mem_addr), 32'(addr));
            chk("mem_dim", 32'(bus.mem_dim), 32'(k));
            chk("busy_read", 32'(bus.busy), 32'd1);
            @(negedge clk);
            #1;
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_id", 32'(bus.rsp_id), 32'(r));
            chk("rsp_dim", 32'(bus.rsp_dim), 32'(k));
            chk("rsp_data", 32'(bus.rsp_data), err ? 32'd0 : 32'(base + k));
            chk("rsp_err", 32'(bus.rsp_err), 32'(err));
            chk("rsp_last", 32'(bus.rsp_last), 32'(k == D - 1));
        end
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("mem_read_after", 32'(bus.mem_read), 32'd0);
        @(negedge clk);
        #1;
        chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
        chk("rsp_last_idle", 32'(bus.rsp_last), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_dim"}, 32'(bus.mem_dim), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
        chk({tag, "_rsp_id_dim"}, 32'({bus.rsp_id, bus.rsp_dim}), 32'd0);
        chk({tag, "_rsp_err_last"}, 32'({bus.rsp_err, bus.rsp_last}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t tbl [5];
        int   n;
        logic [31:0] exp_g;

        tbl[0] = '{r: 0, addr: 5,   base: 80,   err: 1'b0};
        tbl[1] = '{r: 1, addr: 200, base: 0,    err: 1'b1};
        tbl[2] = '{r: 0, addr: 199, base: 3184, err: 1'b0};
        tbl[3] = '{r: 1, addr: 2,   base: 32,   err: 1'b0};
        tbl[4] = '{r: 0, addr: 0,   base: 0,    err: 1'b0};

        bus.req      = '0;
        bus.req_addr = '0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters from reset: R0 first, R1 right after R0's last read.
        @(negedge clk);
        set_req(0, 1'b1, 1);
        set_req(1, 1'b1, 2);
        for (int c = 0; c < 10; c++) begin
            if (c == 1) set_req(0, 1'b0, 1);
            if (c == 5) set_req(1, 1'b0, 2);
            #1;
            exp_g = (c == 0) ? 32'd1 : (c == 4) ? 32'd2 : 32'd0;
            chk("dual_gnt", 32'(bus.gnt), exp_g);
            if (c >= 2 && c <= 4) begin
                chk("dual_r0_data", 32'(bus.rsp_data), 32'(16 + c - 2));
                chk("dual_r0_id", 32'(bus.rsp_id), 32'd0);
            end
            if (c >= 6 && c <= 8) begin
                chk("dual_r1_valid", 32'(bus.rsp_valid), 32'd1);
                chk("dual_r1_data", 32'(bus.rsp_data), 32'(32 + c - 6));
                chk("dual_r1_id", 32'(bus.rsp_id), 32'd1);
                chk("dual_r1_last", 32'(bus.rsp_last), 32'(c == 8));
            end
            @(negedge clk);
        end

        // Held requests alternate grants.
        set_req(0, 1'b1, 3);
        set_req(1, 1'b1, 4);
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            #1;
            if (bus.gnt != '0) begin
                chk("rr_single_gnt", 32'($countones(bus.gnt)), 32'd1);
                chk("rr_order", 32'(bus.gnt[1] ? 1 : 0), 32'(n % 2));
                n++;
            end
            @(negedge clk);
        end
        set_req(0, 1'b0, 3);
        set_req(1, 1'b0, 4);
        chk("rr_count", 32'(n), 32'd6);
        repeat (D + 2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i].r, tbl[i].addr, tbl[i].base, tbl[i].err);
        end

        // Reset in the middle of a transfer.
        @(negedge clk);
        set_req(0, 1'b1, 7);
        #1;
        chk("mid_gnt", 32'(bus.gnt), 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, 7);
        @(negedge clk);
        #1;
        chk("mid_beat0", 32'(bus.rsp_data), 32'd112);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_no_last", 32'(bus.rsp_last), 32'd0);
        run_txn(0, 7, 112, 1'b0);

        // Pointer returns to R-1 on reset: R0 wins despite having won last.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 7);
        set_req(1, 1'b1, 2);
        #1;
        chk("ptr_reset_gnt", 32'(bus.gnt), 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, 7);
        set_req(1, 1'b0, 2);
        repeat (D + 2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
